// File: rtl/frost_pkg.sv
// Shared definitions for the frost core: base opcodes, the NOP encoding and
// the fetch FSM state type.
package frost_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational slicing of a 32-bit instruction into its common fields,
// including the sign-extended I-type immediate.
module instr_fields (
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [31:0] imm_i
);

  always_comb begin
    opcode = instr[6:0];
    rd     = instr[11:7];
    funct3 = instr[14:12];
    rs1    = instr[19:15];
    rs2    = instr[24:20];
    imm_i  = {{20{instr[31]}}, instr[31:20]};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time over a
// valid/ready port and holds the returned word in the instruction register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = frost_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [31:0] imm_i
);

  import frost_pkg::*;

  fetch_state_t state, state_next;
  logic         discard;
  logic         handshake;
  logic         resp_take;
  logic         resp_drop;
  logic [31:0]  pc_next;

  assign handshake = (state == S_REQ) && imem_req_ready;
  assign resp_take = (state == S_WAIT) && imem_resp_valid && !discard && !pc_enable;
  // A stale response may also land in S_REQ after a reset taken in S_WAIT.
  assign resp_drop = imem_resp_valid &&
                     (((state == S_WAIT) && (discard || pc_enable)) ||
                      ((state == S_REQ) && discard));
  assign pc_next   = pc_load ? (pc_target & ~32'd3) : (pc + 32'd4);

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ:  if (handshake)       state_next = S_WAIT;
      S_WAIT: if (imem_resp_valid) state_next = resp_take ? S_HOLD : S_REQ;
      S_HOLD: if (pc_enable)       state_next = S_REQ;
      default:                     state_next = S_REQ;
    endcase
  end

  // instr_valid is high exactly while the FSM sits in S_HOLD.
  always_comb begin
    imem_req_valid = (state == S_REQ);
    instr_valid    = (state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      discard <= (state == S_WAIT) && !imem_resp_valid;
    end else begin
      if (pc_enable) pc <= pc_next;
      if (resp_take) instr <= imem_resp_data;
      if (resp_drop)
        discard <= 1'b0;
      else if (pc_enable && ((state == S_WAIT) || handshake))
        discard <= 1'b1;
    end
  end

  assign imem_addr = pc;

  instr_fields u_fields (
    .instr  (instr),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .imm_i  (imm_i)
  );

  resp_outside_wait: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (state != S_WAIT) && !discard));

endmodule
